// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches
// and delivers {instruction, PC} to decode through an output register plus one skid entry.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetchState_e;

  fetchState_e     state;
  logic [XLEN-1:0] pcQ;
  logic            drop;
  logic            skidValid;
  logic [XLEN-1:0] skidInstr;
  logic [XLEN-1:0] skidPc;

  logic            xfer;
  logic            granted;
  logic            capture;
  logic            toOut;
  logic            toSkid;
  logic            skidValidD;
  logic [XLEN-1:0] pcRedir;
  logic [XLEN-1:0] pcInc;

  assign xfer    = instr_valid & instr_ready;
  assign granted = imem_req & imem_gnt;
  // A response is only meaningful in WAIT; stale ones elsewhere are ignored.
  assign capture = (state == WAIT) & imem_rvalid & ~drop & ~redirect_valid;
  assign toOut   = capture & (~instr_valid | xfer) & ~skidValid;
  assign toSkid  = capture & ~toOut;
  assign pcRedir = redirect_pc & ~XLEN'(3);
  assign pcInc   = pcQ + XLEN'(4);

  // Skid occupancy after this edge; a full skid suppresses the next request.
  assign skidValidD = redirect_valid ? 1'b0 :
                      toSkid         ? 1'b1 :
                      xfer           ? 1'b0 : skidValid;

  // Fetch FSM and registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcQ       <= RESET_PC;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= ~skidValidD;
          if (redirect_valid) begin
            pcQ       <= pcRedir;
            imem_addr <= pcRedir;
          end else begin
            imem_addr <= pcQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            pcQ       <= pcRedir;
            imem_addr <= pcRedir;
          end
          if (granted) begin
            state    <= WAIT;
            imem_req <= 1'b0;
            if (redirect_valid) drop <= 1'b1;
          end else begin
            imem_req <= ~skidValidD;
          end
        end
        WAIT: begin
          imem_req <= 1'b0;
          if (redirect_valid) begin
            pcQ       <= pcRedir;
            imem_addr <= pcRedir;
          end
          if (imem_rvalid) begin
            state    <= REQ;
            drop     <= 1'b0;
            imem_req <= ~skidValidD;
            if (!drop && !redirect_valid) begin
              pcQ       <= pcInc;
              imem_addr <= pcInc;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Output register and skid entry, kept in program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
      pc_out      <= RESET_PC;
      skidValid   <= 1'b0;
      skidInstr   <= NOP_INSTR;
      skidPc      <= RESET_PC;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
      skidValid   <= 1'b0;
    end else begin
      if (xfer) begin
        if (skidValid) begin
          instr_out <= skidInstr;
          pc_out    <= skidPc;
        end else if (toOut) begin
          instr_out <= imem_rdata;
          pc_out    <= pcQ;
        end else begin
          instr_valid <= 1'b0;
          instr_out   <= NOP_INSTR;
        end
      end else if (toOut) begin
        instr_valid <= 1'b1;
        instr_out   <= imem_rdata;
        pc_out      <= pcQ;
      end
      if (toSkid) begin
        skidValid <= 1'b1;
        skidInstr <= imem_rdata;
        skidPc    <= pcQ;
      end else if (xfer) begin
        skidValid <= 1'b0;
      end
    end
  end

endmodule
